// File: rtl/spi_controller_seq.sv
// spi_controller_seq: SPI bus master sequencing multi-byte transactions.
// SCLK idles low, CS is active low, data is shifted MSB first. COPI changes
// together with each SCLK rising edge, and CIPO is captured on each SCLK
// falling edge, one half-bit after the rise.
// Optional feature: define SPI_CONTROLLER_LOOPBACK_EN to add port i_loopback.
// While i_loopback=1, the capture source becomes the controller's own COPI
// instead of i_spi_cipo.
module spi_controller_seq #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_IDLE_CLKS      = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_busy,
    output logic       o_spi_clk,
    output logic       o_spi_copi,
    input  logic       i_spi_cipo,
`ifdef SPI_CONTROLLER_LOOPBACK_EN
    input  logic       i_loopback,
`endif
    output logic       o_spi_cs_n
);

    localparam int HALF_W = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam int GAP_W  = (CS_IDLE_CLKS > 1) ? $clog2(CS_IDLE_CLKS) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_IDLE_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SCLK_HIGH,
        SCLK_LOW,
        WAIT_BYTE,
        CS_HOLD,
        CS_GAP
    } state_t;

    state_t              state;
    logic [HALF_W-1:0]   half_cnt;
    logic [2:0]          bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [7:0]          tx_sr;
    logic [7:0]          rx_sr;
    logic                last_q;
    logic                sample_bit;
    logic                half_done;

    // Capture source for the incoming bit
`ifdef SPI_CONTROLLER_LOOPBACK_EN
    assign sample_bit = i_loopback ? o_spi_copi : i_spi_cipo;
`else
    assign sample_bit = i_spi_cipo;
`endif

    assign half_done  = (half_cnt == HALF_LAST);

    // Handshake and status are decoded straight from the state register
    assign o_tx_ready = (state == IDLE) || (state == WAIT_BYTE);
    assign o_busy     = (state != IDLE);

    // Transaction sequencer: state, counters, shift registers and SPI pins
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            half_cnt   <= '0;
            bit_cnt    <= 3'd0;
            gap_cnt    <= '0;
            tx_sr      <= 8'h00;
            rx_sr      <= 8'h00;
            last_q     <= 1'b0;
            o_rx_dv    <= 1'b0;
            o_rx_byte  <= 8'h00;
            o_spi_clk  <= 1'b0;
            o_spi_copi <= 1'b0;
            o_spi_cs_n <= 1'b1;
        end else begin
            o_rx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_tx_dv) begin
                        tx_sr      <= i_tx_byte;
                        last_q     <= i_tx_last;
                        o_spi_cs_n <= 1'b0;
                        o_spi_copi <= i_tx_byte[7];
                        half_cnt   <= '0;
                        bit_cnt    <= 3'd0;
                        state      <= CS_SETUP;
                    end
                end

                CS_SETUP: begin
                    if (half_done) begin
                        half_cnt  <= '0;
                        o_spi_clk <= 1'b1;
                        state     <= SCLK_HIGH;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                SCLK_HIGH: begin
                    if (half_done) begin
                        half_cnt  <= '0;
                        o_spi_clk <= 1'b0;
                        rx_sr     <= {rx_sr[6:0], sample_bit};
                        state     <= SCLK_LOW;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                SCLK_LOW: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            // Byte complete: hand it up and decide whether CS stays low
                            bit_cnt   <= 3'd0;
                            o_rx_dv   <= 1'b1;
                            o_rx_byte <= rx_sr;
                            state     <= last_q ? CS_HOLD : WAIT_BYTE;
                        end else begin
                            bit_cnt    <= bit_cnt + 3'd1;
                            o_spi_copi <= tx_sr[6];
                            tx_sr      <= {tx_sr[6:0], 1'b0};
                            o_spi_clk  <= 1'b1;
                            state      <= SCLK_HIGH;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                WAIT_BYTE: begin
                    // CS held low with SCLK parked low until the next byte arrives
                    if (i_tx_dv) begin
                        tx_sr      <= i_tx_byte;
                        last_q     <= i_tx_last;
                        o_spi_copi <= i_tx_byte[7];
                        half_cnt   <= '0;
                        bit_cnt    <= 3'd0;
                        state      <= CS_SETUP;
                    end
                end

                CS_HOLD: begin
                    if (half_done) begin
                        half_cnt   <= '0;
                        o_spi_cs_n <= 1'b1;
                        o_spi_copi <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= CS_GAP;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                CS_GAP: begin
                    // Requests are not accepted here, so CS stays high for the full gap
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
